mem_stage: RTL and testbench

//  Load/store unit directly downstream of the execute stage. Consumes the EX result as effective address, rs2 as store data and funct3 as access size.

---
 rtl/arvi_mem_pkg.sv | 48 ++++
 rtl/load_align.sv | 30 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_mem_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 size
// codes, and the size/alignment/byte-enable decode used by the stage and aligner.
package arvi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Undefined funct3 codes behave as word accesses; the decoder traps them.
    function automatic size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = ~off[0];
            default: is_aligned = (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_B:    be_gen = 4'b0001 << off;
            SZ_H:    be_gen = 4'b0011 << {off[1], 1'b0};
            default: be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the byte/half lane addressed by off and sign- or
// zero-extends it. Purely combinational so other units can share it.
module load_align
    import arvi_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      f3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        byte_lane = rdata[{off, 3'b000} +: 8];
        half_lane = rdata[{off[1], 4'b0000} +: 16];
        // funct3[2] marks the unsigned variants (LBU/LHU)
        sext      = ~f3[2];
        case (size_of(f3))
            SZ_B:    data = {{(XLEN-8){sext & byte_lane[7]}}, byte_lane};
            SZ_H:    data = {{(XLEN-16){sext & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: single-outstanding req/ack data-bus master with load
// formatting, pipeline stall, misalignment flags and ack timeout.
module mem_stage
    import arvi_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [2:0]      i_f3,
    input  logic            i_memread,
    input  logic            i_memwrite,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [XLEN-1:0] o_dbus_wdata,
    output logic [3:0]      o_dbus_be,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_stall,
    output logic            o_misaligned_ld,
    output logic            o_misaligned_st,
    output logic            o_bus_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (ACK_TIMEOUT > 0);

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [XLEN-1:0]  ld_fmt;
    logic             access;
    logic             aligned;
    logic             start;
    logic             timeout_hit;

    function automatic logic [XLEN-1:0] wdata_rep(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (size_of(f3))
            SZ_B:    wdata_rep = {(XLEN/8){d[7:0]}};
            SZ_H:    wdata_rep = {(XLEN/16){d[15:0]}};
            default: wdata_rep = d;
        endcase
    endfunction

    assign access  = i_memread | i_memwrite;
    assign aligned = is_aligned(i_f3, i_addr[1:0]);
    assign start   = (state == IDLE) && access && aligned;

    // Flags only mean something while a new instruction is being offered (IDLE);
    // a write wins when both requests are raised.
    assign o_misaligned_st = (state == IDLE) && i_memwrite && !aligned;
    assign o_misaligned_ld = (state == IDLE) && i_memread && !i_memwrite && !aligned;
    assign o_stall         = start || (state == BUSY);
    assign timeout_hit     = TIMEOUT_EN && (busy_cnt == CNT_LAST);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata (i_dbus_rdata),
        .f3    (f3_q),
        .off   (off_q),
        .data  (ld_fmt)
    );

    // Stage boundary: request/latch registers and bus handshake FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_addr  <= '0;
            o_dbus_wdata <= '0;
            o_dbus_be    <= 4'b0000;
            o_rd_data    <= '0;
            o_bus_err    <= 1'b0;
            busy_cnt     <= '0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        o_dbus_req   <= 1'b1;
                        o_dbus_we    <= i_memwrite;
                        o_dbus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_dbus_be    <= be_gen(i_f3, i_addr[1:0]);
                        o_dbus_wdata <= wdata_rep(i_f3, i_wr_data);
                        f3_q         <= i_f3;
                        off_q        <= i_addr[1:0];
                        busy_cnt     <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_dbus_ack) begin
                        o_dbus_req <= 1'b0;
                        if (!o_dbus_we) begin
                            o_rd_data <= ld_fmt;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        o_dbus_req <= 1'b0;
                        o_bus_err  <= 1'b1;
                        o_rd_data  <= '0;
                        state      <= DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_bus_err <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: bus-slave driver plus per-scenario tasks
// that queue expected transactions and compare them against what the DUT did.
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_addr, i_wr_data, i_dbus_rdata;
    logic [2:0]  i_f3;
    logic        i_memread, i_memwrite, i_dbus_ack;
    logic        o_dbus_req, o_dbus_we, o_stall, o_misaligned_ld, o_misaligned_st, o_bus_err;
    logic [31:0] o_dbus_addr, o_dbus_wdata, o_rd_data;
    logic [3:0]  o_dbus_be;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          stall;
        int          busy;
        logic        err;
    } exp_t;

    typedef struct {
        logic        req_seen;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          stall;
        int          busy;
        logic        err;
        logic        err_after;
        logic        done_stall;
        logic        mis_ld;
        logic        mis_st;
    } obs_t;

    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    mem_stage #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_addr          (i_addr),
        .i_wr_data       (i_wr_data),
        .i_f3            (i_f3),
        .i_memread       (i_memread),
        .i_memwrite      (i_memwrite),
        .o_dbus_req      (o_dbus_req),
        .o_dbus_we       (o_dbus_we),
        .o_dbus_addr     (o_dbus_addr),
        .o_dbus_wdata    (o_dbus_wdata),
        .o_dbus_be       (o_dbus_be),
        .i_dbus_ack      (i_dbus_ack),
        .i_dbus_rdata    (i_dbus_rdata),
        .o_rd_data       (o_rd_data),
        .o_stall         (o_stall),
        .o_misaligned_ld (o_misaligned_ld),
        .o_misaligned_st (o_misaligned_st),
        .o_bus_err       (o_bus_err)
    );

    // Called 1ns after a rising edge with the DUT idle; acts as the bus slave,
    // acking in BUSY cycle ack_at (0 = never ack).
    task automatic drive_access(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f3,
                                input int ack_at, input logic [31:0] rdata, output obs_t o);
        int guard;
        o = '{default: 0};
        i_addr = a; i_wr_data = d; i_f3 = f3; i_memread = rd; i_memwrite = wr;
        #1;
        o.mis_ld = o_misaligned_ld;
        o.mis_st = o_misaligned_st;
        if (o_stall) o.stall++;
        @(posedge i_clk); #1;
        o.req_seen = o_dbus_req;
        o.we = o_dbus_we; o.addr = o_dbus_addr; o.be = o_dbus_be; o.wdata = o_dbus_wdata;
        guard = 0;
        while (o_dbus_req && guard < 20) begin
            o.busy++;
            if (o_stall) o.stall++;
            if (o.busy == ack_at) begin i_dbus_ack = 1'b1; i_dbus_rdata = rdata; end
            @(posedge i_clk); #1;
            i_dbus_ack = 1'b0;
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL bus_bound: req still high after %0d cycles, limit 20", guard);
        end
        o.done_stall = o_stall; o.rd = o_rd_data; o.err = o_bus_err;
        i_memread = 1'b0; i_memwrite = 1'b0;
        if (o.req_seen) begin
            @(posedge i_clk); #1;
            o.err_after = o_bus_err;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_addr = 32'h0; i_wr_data = 32'h0; i_f3 = 3'b000;
        i_memread = 1'b0; i_memwrite = 1'b0; i_dbus_ack = 1'b0; i_dbus_rdata = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", o_dbus_req); end
        checks++; if (o_dbus_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", o_dbus_we); end
        checks++; if ({o_dbus_addr, o_dbus_wdata} !== 64'h0) begin errors++; $display("FAIL rst_addr_wdata got %h %h exp 0", o_dbus_addr, o_dbus_wdata); end
        checks++; if (o_dbus_be !== 4'b0000) begin errors++; $display("FAIL rst_be got %b exp 0000", o_dbus_be); end
        checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd got %h exp 0", o_rd_data); end
        checks++; if ({o_bus_err, o_stall} !== 2'b00) begin errors++; $display("FAIL rst_err_stall got %b exp 00", {o_bus_err, o_stall}); end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_load_word();
        exp_t e; obs_t o;
        exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0, rd: 32'hDEADBEEF, stall: 4, busy: 3, err: 1'b0});
        drive_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 3, 32'hDEADBEEF, o);
        e = exp_q.pop_front();
        checks++; if (o.req_seen !== 1'b1) begin errors++; $display("FAIL lw_req got %b exp 1", o.req_seen); end
        checks++; if (o.addr !== e.addr || o.we !== e.we) begin errors++; $display("FAIL lw_addr_we got %h/%b exp %h/%b", o.addr, o.we, e.addr, e.we); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL lw_be got %b exp %b", o.be, e.be); end
        checks++; if (o.stall != e.stall || o.busy != e.busy) begin errors++; $display("FAIL lw_stall got %0d/%0d exp %0d/%0d", o.stall, o.busy, e.stall, e.busy); end
        checks++; if (o.rd !== e.rd) begin errors++; $display("FAIL lw_rd got %h exp %h", o.rd, e.rd); end
        checks++; if (o.done_stall !== 1'b0 || o.err !== e.err) begin errors++; $display("FAIL lw_done got stall=%b err=%b exp 0/0", o.done_stall, o.err); end
    endtask

    task automatic test_load_byte();
        exp_t e; obs_t o;
        exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'h0, rd: 32'hFFFFFF80, stall: 2, busy: 1, err: 1'b0});
        drive_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 1, 32'h80FF_0000, o);
        e = exp_q.pop_front();
        checks++; if (o.addr !== e.addr || o.be !== e.be) begin errors++; $display("FAIL lb_addr_be got %h/%b exp %h/%b", o.addr, o.be, e.addr, e.be); end
        checks++; if (o.rd !== e.rd) begin errors++; $display("FAIL lb_rd got %h exp %h", o.rd, e.rd); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL lb_stall got %0d exp %0d", o.stall, e.stall); end
        exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'h0, rd: 32'h00000080, stall: 2, busy: 1, err: 1'b0});
        drive_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h80FF_0000, o);
        e = exp_q.pop_front();
        checks++; if (o.rd !== e.rd) begin errors++; $display("FAIL lbu_rd got %h exp %h", o.rd, e.rd); end
    endtask

    task automatic test_store_half();
        exp_t e; obs_t o;
        exp_q.push_back('{we: 1'b1, addr: 32'h200, be: 4'b1100, wdata: 32'hABCDABCD, rd: 32'h00000080, stall: 3, busy: 2, err: 1'b0});
        drive_access(1'b0, 1'b1, 32'h202, 32'h1234ABCD, 3'b001, 2, 32'hFFFF_FFFF, o);
        e = exp_q.pop_front();
        checks++; if (o.we !== e.we || o.addr !== e.addr) begin errors++; $display("FAIL sh_we_addr got %b/%h exp %b/%h", o.we, o.addr, e.we, e.addr); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL sh_be got %b exp %b", o.be, e.be); end
        checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL sh_wdata got %h exp %h", o.wdata, e.wdata); end
        checks++; if (o.rd !== e.rd) begin errors++; $display("FAIL sh_rd_kept got %h exp %h", o.rd, e.rd); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        drive_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 1, 32'h0, o);
        checks++; if ({o.mis_ld, o.mis_st} !== 2'b10) begin errors++; $display("FAIL mis_lw_flags got %b exp 10", {o.mis_ld, o.mis_st}); end
        checks++; if (o.stall != 0 || o.req_seen !== 1'b0) begin errors++; $display("FAIL mis_lw_bus got stall=%0d req=%b exp 0/0", o.stall, o.req_seen); end
        drive_access(1'b0, 1'b1, 32'h003, 32'h5555, 3'b001, 1, 32'h0, o);
        checks++; if ({o.mis_ld, o.mis_st} !== 2'b01) begin errors++; $display("FAIL mis_sh_flags got %b exp 01", {o.mis_ld, o.mis_st}); end
        checks++; if (o.stall != 0 || o.req_seen !== 1'b0) begin errors++; $display("FAIL mis_sh_bus got stall=%0d req=%b exp 0/0", o.stall, o.req_seen); end
    endtask

    task automatic test_timeout();
        exp_t e; obs_t o;
        exp_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'h0, rd: 32'h0, stall: 5, busy: 4, err: 1'b1});
        drive_access(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 0, 32'h0, o);
        e = exp_q.pop_front();
        checks++; if (o.busy != e.busy) begin errors++; $display("FAIL to_busy got %0d exp %0d", o.busy, e.busy); end
        checks++; if (o.err !== e.err || o.rd !== e.rd) begin errors++; $display("FAIL to_err_rd got %b/%h exp %b/%h", o.err, o.rd, e.err, e.rd); end
        checks++; if (o.err_after !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b exp 0", o.err_after); end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        exp_t tbl[4];
        logic [31:0] a_tbl[4] = '{32'h11, 32'h12, 32'h10, 32'h20};
        logic [31:0] d_tbl[4] = '{32'h000000A5, 32'h0, 32'h0, 32'hCAFEF00D};
        logic [31:0] r_tbl[4] = '{32'h0, 32'h80017FFF, 32'h12348000, 32'h0};
        logic [2:0]  f_tbl[4] = '{3'b000, 3'b001, 3'b101, 3'b010};
        logic        rd_tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        wr_tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[0] = '{we: 1'b1, addr: 32'h10, be: 4'b0010, wdata: 32'hA5A5A5A5, rd: 32'h0,        stall: 2, busy: 1, err: 1'b0};
        tbl[1] = '{we: 1'b0, addr: 32'h10, be: 4'b1100, wdata: 32'h0,        rd: 32'hFFFF8001, stall: 2, busy: 1, err: 1'b0};
        tbl[2] = '{we: 1'b0, addr: 32'h10, be: 4'b0011, wdata: 32'h0,        rd: 32'h00008000, stall: 2, busy: 1, err: 1'b0};
        tbl[3] = '{we: 1'b1, addr: 32'h20, be: 4'b1111, wdata: 32'hCAFEF00D, rd: 32'h00008000, stall: 2, busy: 1, err: 1'b0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(tbl[i]);
            drive_access(rd_tbl[i], wr_tbl[i], a_tbl[i], d_tbl[i], f_tbl[i], 1, r_tbl[i], o);
            e = exp_q.pop_front();
            checks++; if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be) begin errors++; $display("FAIL b2b%0d_bus got %b/%h/%b exp %b/%h/%b", i, o.we, o.addr, o.be, e.we, e.addr, e.be); end
            checks++; if (e.we && o.wdata !== e.wdata) begin errors++; $display("FAIL b2b%0d_wdata got %h exp %h", i, o.wdata, e.wdata); end
            checks++; if (o.rd !== e.rd || o.stall != e.stall) begin errors++; $display("FAIL b2b%0d_rd_stall got %h/%0d exp %h/%0d", i, o.rd, o.stall, e.rd, e.stall); end
        end
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        drive_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 1, 32'h0BADF00D, o);
        checks++; if (o.rd !== 32'h0BADF00D) begin errors++; $display("FAIL rmb_pre_rd got %h exp 0badf00d", o.rd); end
        i_addr = 32'h44; i_f3 = 3'b010; i_memread = 1'b1;
        @(posedge i_clk); #1;
        checks++; if (o_dbus_req !== 1'b1) begin errors++; $display("FAIL rmb_busy_req got %b exp 1", o_dbus_req); end
        i_rst = 1'b1; i_memread = 1'b0;
        @(posedge i_clk); #1;
        checks++; if (o_dbus_req !== 1'b0 || o_rd_data !== 32'h0) begin errors++; $display("FAIL rmb_rst_edge got req=%b rd=%h exp 0/0", o_dbus_req, o_rd_data); end
        i_rst = 1'b0; i_dbus_ack = 1'b1; i_dbus_rdata = 32'h12345678;
        @(posedge i_clk); #1;
        i_dbus_ack = 1'b0;
        checks++; if (o_dbus_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL rmb_late_ack got req=%b stall=%b exp 0/0", o_dbus_req, o_stall); end
        checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL rmb_rd got %h exp 0", o_rd_data); end
        @(posedge i_clk); #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL rmb_idle_req got %b exp 0", o_dbus_req); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
